// File: rtl/cpu_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl_if
// Purpose  : Board/CPU-side signal bundle of the picoMIPS run-control sequencer.
//            cyc_cnt exists only when CYCLE_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface cpu_run_ctrl_if;
    logic       run_sw;
    logic       step_btn;
    logic       cpu_halt;
    logic       cpu_en;
    logic       cpu_rst;
    logic [1:0] state_o;
`ifdef CYCLE_COUNT_EN
    logic [15:0] cyc_cnt;

    modport master (output run_sw, step_btn, cpu_halt,
                    input  cpu_en, cpu_rst, state_o, cyc_cnt);
    modport slave  (input  run_sw, step_btn, cpu_halt,
                    output cpu_en, cpu_rst, state_o, cyc_cnt);
`else
    modport master (output run_sw, step_btn, cpu_halt,
                    input  cpu_en, cpu_rst, state_o);
    modport slave  (input  run_sw, step_btn, cpu_halt,
                    output cpu_en, cpu_rst, state_o);
`endif
endinterface
`default_nettype wire

// File: rtl/cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_ctrl
// Purpose  : picoMIPS run-control sequencer: CPU reset, prescaled free-run,
//            debounced single-step and halt detection via a clock enable.
//            Optional macro CYCLE_COUNT_EN adds a saturating step counter.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_ctrl #(
    parameter int N          = 24,
    parameter int DB         = 16,
    parameter int RST_CYCLES = 4
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    cpu_run_ctrl_if.slave bus
);

    localparam logic [7:0] c_RST_LAST = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_en_nxt;
    logic            r_cpu_en;
    logic            r_cpu_rst;
    logic [7:0]      r_rst_cnt;
    logic            r_run_meta, r_run_s;
    logic            r_btn_meta, r_btn_s;
    logic [DB-1:0]   r_db_cnt;
    logic            r_btn_db, r_btn_db_q;
    logic [N-1:0]    r_presc;
    logic            w_tick;
    logic            w_step_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_meta <= 1'b0;
            r_run_s    <= 1'b0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_run_meta <= bus.run_sw;
            r_run_s    <= r_run_meta;
            r_btn_meta <= bus.step_btn;
            r_btn_s    <= r_btn_meta;
        end
    end

    // Debounced level flips only after 2^DB consecutive clocks of disagreement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db_cnt   <= '0;
            r_btn_db   <= 1'b0;
            r_btn_db_q <= 1'b0;
        end else begin
            r_btn_db_q <= r_btn_db;
            if (r_btn_s == r_btn_db) begin
                r_db_cnt <= '0;
            end else if (&r_db_cnt) begin
                r_btn_db <= r_btn_s;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_step_req = r_btn_db & ~r_btn_db_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = &r_presc;

    // Halt beats a mode change, which beats the step source in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_rst_cnt == c_RST_LAST) begin
                    w_state_nxt = r_run_s ? S_RUN : S_PAUSE;
                end
            end
            S_RUN: begin
                if (bus.cpu_halt) begin
                    w_state_nxt = S_HALT;
                end else if (!r_run_s) begin
                    w_state_nxt = S_PAUSE;
                end else begin
                    w_en_nxt = w_tick;
                end
            end
            S_PAUSE: begin
                if (bus.cpu_halt) begin
                    w_state_nxt = S_HALT;
                end else if (r_run_s) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_en_nxt = w_step_req;
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_INIT;
            r_cpu_en  <= 1'b0;
            r_cpu_rst <= 1'b1;
            r_rst_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpu_en  <= w_en_nxt;
            r_cpu_rst <= (w_state_nxt == S_INIT);
            if (r_state == S_INIT) begin
                r_rst_cnt <= r_rst_cnt + 1'b1;
            end
        end
    end

    assign bus.cpu_en  = r_cpu_en;
    assign bus.cpu_rst = r_cpu_rst;
    assign bus.state_o = r_state;

`ifdef CYCLE_COUNT_EN
    logic [15:0] r_cyc_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cyc_cnt <= '0;
        end else if (r_cpu_en && (r_cyc_cnt != 16'hFFFF)) begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
        end
    end

    assign bus.cyc_cnt = r_cyc_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_ctrl
// Purpose  : Directed self-checking bench for cpu_run_ctrl (N=4, DB=2,
//            RST_CYCLES=4); counter checks build only with CYCLE_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int N          = 4;
    localparam int DB         = 2;
    localparam int RST_CYCLES = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   cyc;

    always #5 clk = ~clk;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .N          (N),
        .DB         (DB),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Edges since reset release; equals the prescaler value modulo 2^N.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clks(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step_clk();
            if (bus.cpu_en === 1'b1) pulses++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p;
        int first;
        int last;
        int hi;
        bit found;

        bus.run_sw   = 1'b1;
        bus.step_btn = 1'b0;
        bus.cpu_halt = 1'b0;

        // Reset state
        step_clk();
        step_clk();
        chk("rst_cpu_en", bus.cpu_en, 0);
        chk("rst_cpu_rst", bus.cpu_rst, 1);
        chk("rst_state", bus.state_o, 0);

        // 1: free-run after reset release
        reset_n = 1'b1;
        step_clk();
        step_clk();
        step_clk();
        chk("t1_rst_held_edge3", bus.cpu_rst, 1);
        chk("t1_state_init_edge3", bus.state_o, 0);
        step_clk();
        chk("t1_rst_released_edge4", bus.cpu_rst, 0);
        chk("t1_state_run", bus.state_o, 1);
        first = -1;
        last  = -1;
        hi    = 0;
        for (int i = 0; i < 46; i++) begin
            step_clk();
            if (bus.cpu_en === 1'b1) begin
                hi++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        chk("t1_pulse_high_cycles", hi, 3);
        chk("t1_first_pulse_edge", first, 16);
        chk("t1_last_pulse_edge", last, 48);

        // 2: single-step with a clean held button
        bus.run_sw = 1'b0;
        run_clks(5, p);
        chk("t2_no_pulse_mode_change", p, 0);
        chk("t2_state_pause", bus.state_o, 2);
        bus.step_btn = 1'b1;
        run_clks(8, p);
        chk("t2_one_step_pulse", p, 1);
        run_clks(4, p);
        chk("t2_none_while_held", p, 0);
        bus.step_btn = 1'b0;
        run_clks(10, p);
        chk("t2_none_on_release", p, 0);
        chk("t2_state_still_pause", bus.state_o, 2);

        // 3: bouncing button then stable high
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            bus.step_btn = (i % 2 == 0);
            step_clk();
            if (bus.cpu_en === 1'b1) hi++;
        end
        bus.step_btn = 1'b1;
        run_clks(10, p);
        chk("t3_bounce_one_pulse", hi + p, 1);
        bus.step_btn = 1'b0;
        run_clks(10, p);
        chk("t3_none_after_release", p, 0);

        // 4: halt on the tick cycle
        bus.run_sw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step_clk();
            if (bus.state_o === 2'b01) found = 1'b1;
        end
        chk("t4_reached_run", found, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cyc % 16 == 15) found = 1'b1;
            else step_clk();
        end
        chk("t4_reached_tick", found, 1);
        bus.cpu_halt = 1'b1;
        step_clk();
        chk("t4_no_pulse_on_halt", bus.cpu_en, 0);
        chk("t4_state_halt", bus.state_o, 3);
        bus.cpu_halt = 1'b0;
        hi = 0;
        for (int i = 0; i < 48; i++) begin
            bus.run_sw   = (i % 16) < 8;
            bus.step_btn = (i % 12) < 7;
            step_clk();
            if (bus.cpu_en === 1'b1) hi++;
        end
        chk("t4_halt_no_pulses", hi, 0);
        chk("t4_halt_sticky", bus.state_o, 3);

        // 5: async reset mid-RUN
        bus.run_sw   = 1'b1;
        bus.step_btn = 1'b0;
        reset_n      = 1'b0;
        step_clk();
        step_clk();
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step_clk();
            if (bus.cpu_en === 1'b1) found = 1'b1;
        end
        chk("t5_pulse_seen", found, 1);
        chk("t5_pulse_edge", cyc, 16);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_cpu_en", bus.cpu_en, 0);
        chk("t5_async_cpu_rst", bus.cpu_rst, 1);
        chk("t5_async_state", bus.state_o, 0);

`ifdef CYCLE_COUNT_EN
        // 6: step counter and saturation
        chk("t6_cnt_reset", bus.cyc_cnt, 0);
        bus.run_sw = 1'b0;
        step_clk();
        reset_n = 1'b1;
        run_clks(8, p);
        for (int k = 0; k < 5; k++) begin
            bus.step_btn = 1'b1;
            run_clks(8, p);
            bus.step_btn = 1'b0;
            run_clks(8, p);
        end
        chk("t6_cnt_five", bus.cyc_cnt, 5);
        force dut.r_cyc_cnt = 16'hFFFD;
        step_clk();
        release dut.r_cyc_cnt;
        for (int k = 0; k < 3; k++) begin
            bus.step_btn = 1'b1;
            run_clks(8, p);
            bus.step_btn = 1'b0;
            run_clks(8, p);
        end
        chk("t6_cnt_saturated", bus.cyc_cnt, 16'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
